imem_port_arbiter: RTL and testbench
====================================

Name: imem_port_arbiter

Overview:
Shares the single synchronous-read instruction/boot memory between two read requesters: instruction fetch (if_) and data-side read (dm_, for loads from the text/rodata region). It has valid/ready request handshakes, routes each 1-cycle-latency memory read back to the correct requester, and holds that response until the requester accepts it. It also range- and alignment-checks addresses against the memory window. It sits between the core front-end/LSU and the memory; the memory is unchanged.

Parameters:
BASE_ADDR, 32'h8000_0000, first byte address of memory window
MEM_BYTES, 16392, window size in bytes; valid word addrs BASE_ADDR .. BASE_ADDR+MEM_BYTES-4
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
if_req_valid  in  1  fetch request
if_req_ready  out  1  fetch request accepted this cycle when valid&ready
if_req_addr  in  ADDR_W  fetch byte address
if_rsp_valid  out  1  fetch response valid
if_rsp_ready  in  1  fetch consumer accepts response
if_rsp_data  out  DATA_W  fetched word
if_rsp_err  out  1  misaligned or out-of-window
dm_req_valid / dm_req_ready / dm_req_addr / dm_rsp_valid / dm_rsp_ready / dm_rsp_data / dm_rsp_err  same as if_*, data side
mem_addr  out  ADDR_W  address to memory, sampled by memory at posedge
mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_addr sampled

Behaviour:
- Per-port state: IDLE, WAIT (read issued last cycle, data on mem_rdata now), HOLD (response captured, waiting for rsp_ready).
- Eligible: port in IDLE; or in WAIT with rsp_ready=1 this cycle (back-to-back); never in HOLD.
- Grant (combinational): among eligible ports with req_valid=1, dm beats if. req_ready=1 only for the granted port; at most one grant per cycle.
- Accept at cycle T -> port enters WAIT at T+1. In WAIT, rsp_valid=1; rsp_data=mem_rdata (pass-through), or 0 for an error request.
  - rsp_ready=1 at T+1: response consumed. Next state is WAIT if a new request was accepted at T+1, else IDLE.
  - rsp_ready=0 at T+1: capture data/err into the hold register; enter HOLD and present the hold register until rsp_ready=1, then go to IDLE.
- Minimum latency is 1 cycle; full throughput is 1 read/cycle aggregate.
- mem_addr: equals the granted req_addr in the grant cycle if that request is error-free; otherwise it holds a registered last-issued address.
- Error request (addr[1:0]!=0, addr<BASE_ADDR, or addr>BASE_ADDR+MEM_BYTES-4): accepted normally and uses the grant slot, but is not issued to memory. Response follows the same timing with rsp_err=1 and rsp_data=0.
- Window compare uses unsigned ADDR_W+1-bit arithmetic so the upper-bound sum cannot wrap.
- Simultaneous requests, both eligible: dm granted; if stays valid with ready=0 and must hold addr stable.
- A HOLD port blocks only itself; the other port continues at full rate.
- Reset values: all rsp_valid=0, rsp_err=0, rsp_data=0, states IDLE, mem_addr register=BASE_ADDR, priority pointer=0 (dm). req_ready is combinational, so it is 1 after reset whenever req_valid=1 and the port wins.
- Reset asserted mid-operation: in-flight and held responses are dropped; no rsp_valid after reset release without a new request.

Optional Feature:
IMEM_ARB_ROUND_ROBIN_EN
- Defined: a 1-bit priority pointer selects the higher-priority port. After any grant, the pointer moves to the other port. Resets to dm.
- Undefined: fixed priority, dm over if; pointer logic is absent.

Test Plan:
1. Memory preloaded, word @0x8000_0000=0x0000_0013. Single if request addr 0x8000_0000, rsp_ready=1 -> if_rsp_valid at T+1 with data 0x0000_0013, err=0; state back to IDLE.
2. if and dm both valid at T, addrs 0x8000_0004 / 0x8000_0008 -> dm_req_ready=1, if_req_ready=0 at T; if granted at T+1; responses at T+1 (dm) and T+2 (if) with the correct words.
3. dm_rsp_ready=0 for 3 cycles after an accept -> dm_rsp_valid stays 1 with stable data; dm_req_ready=0 throughout; if traffic still completes 1/cycle.
4. Addresses 0x8000_0002, 0x7FFF_FFFC, 0x8000_4008 -> each rsp_err=1, rsp_data=0; mem_addr unchanged from the previous good address.
5. Back-to-back if stream 0x8000_0000,_04,_08 with rsp_ready=1 -> if_req_ready=1 every cycle; three consecutive rsp_valid cycles in order.
6. rst_n low during WAIT -> rsp_valid=0 immediately (async). After release, no response until a new request. With IMEM_ARB_ROUND_ROBIN_EN, continuous dual requests alternate grants dm, if, dm, if.

Source files
------------

// File: rtl/imem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_port_arbiter
// Purpose  : Shares one synchronous-read (1-cycle latency) instruction/boot
//            memory between the fetch port (if_*) and the data-read port
//            (dm_*). Valid/ready request handshakes, response routing with a
//            per-port hold register, and address window/alignment checking.
// Options  : IMEM_ARB_ROUND_ROBIN_EN - when defined, a 1-bit pointer
//            alternates priority after every grant; otherwise dm always wins.
// Revision : 1.0 - initial release
// ============================================================================
module imem_port_arbiter #(
  parameter int unsigned            ADDR_W    = 32,
  parameter int unsigned            DATA_W    = 32,
  parameter logic [ADDR_W-1:0]      BASE_ADDR = 32'h8000_0000,
  parameter int unsigned            MEM_BYTES = 16392
) (
  input  logic              clk,
  input  logic              rst_n,
  // fetch port
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_rsp_valid,
  input  logic              if_rsp_ready,
  output logic [DATA_W-1:0] if_rsp_data,
  output logic              if_rsp_err,
  // data-read port
  input  logic              dm_req_valid,
  output logic              dm_req_ready,
  input  logic [ADDR_W-1:0] dm_req_addr,
  output logic              dm_rsp_valid,
  input  logic              dm_rsp_ready,
  output logic [DATA_W-1:0] dm_rsp_data,
  output logic              dm_rsp_err,
  // memory
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int c_NPORT = 2;
  localparam int c_DM    = 0;
  localparam int c_IF    = 1;

  // Window bounds in ADDR_W+1 bits so BASE_ADDR+MEM_BYTES cannot wrap.
  localparam logic [ADDR_W:0] c_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] c_HI = {1'b0, BASE_ADDR} + (ADDR_W+1)'(MEM_BYTES)
                                     - (ADDR_W+1)'(4);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,   // nothing outstanding
    ST_WAIT = 2'd1,   // read issued last cycle, data is on mem_rdata now
    ST_HOLD = 2'd2    // response captured, waiting for rsp_ready
  } port_state_t;

  logic [c_NPORT-1:0]             w_req_valid;
  logic [c_NPORT-1:0]             w_rsp_ready;
  logic [c_NPORT-1:0][ADDR_W-1:0] w_req_addr;
  logic [c_NPORT-1:0]             w_err;
  logic [c_NPORT-1:0]             w_want;
  logic [c_NPORT-1:0]             w_gnt;
  logic [c_NPORT-1:0]             w_rsp_valid;
  logic [c_NPORT-1:0]             w_rsp_err;
  logic [c_NPORT-1:0][DATA_W-1:0] w_rsp_data;
  logic                           w_issue;
  logic [ADDR_W-1:0]              w_issue_addr;
  logic [ADDR_W-1:0]              r_last_addr;

  assign w_req_valid = {if_req_valid, dm_req_valid};
  assign w_rsp_ready = {if_rsp_ready, dm_rsp_ready};
  assign w_req_addr  = {if_req_addr, dm_req_addr};

  assign dm_req_ready = w_gnt[c_DM];
  assign if_req_ready = w_gnt[c_IF];
  assign dm_rsp_valid = w_rsp_valid[c_DM];
  assign if_rsp_valid = w_rsp_valid[c_IF];
  assign dm_rsp_err   = w_rsp_err[c_DM];
  assign if_rsp_err   = w_rsp_err[c_IF];
  assign dm_rsp_data  = w_rsp_data[c_DM];
  assign if_rsp_data  = w_rsp_data[c_IF];

  for (genvar p = 0; p < c_NPORT; p++) begin : g_port
    port_state_t       r_state;
    logic              r_pend_err;
    logic              r_hold_err;
    logic [DATA_W-1:0] r_hold_data;

    assign w_err[p] = (w_req_addr[p][1:0] != 2'b00)
                    | ({1'b0, w_req_addr[p]} < c_LO)
                    | ({1'b0, w_req_addr[p]} > c_HI);

    // A port may take a new request when idle, or when its current response
    // is being consumed this cycle; a held response blocks only this port.
    assign w_want[p] = w_req_valid[p]
                     & ((r_state == ST_IDLE) | ((r_state == ST_WAIT) & w_rsp_ready[p]));

    assign w_rsp_valid[p] = (r_state == ST_WAIT) | (r_state == ST_HOLD);

    // Response mux: live memory data in WAIT, captured copy in HOLD.
    always_comb begin
      w_rsp_err[p]  = 1'b0;
      w_rsp_data[p] = '0;
      if (r_state == ST_WAIT) begin
        w_rsp_err[p]  = r_pend_err;
        w_rsp_data[p] = r_pend_err ? '0 : mem_rdata;
      end else if (r_state == ST_HOLD) begin
        w_rsp_err[p]  = r_hold_err;
        w_rsp_data[p] = r_hold_data;
      end
    end

    // Per-port response FSM with hold register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state     <= ST_IDLE;
        r_pend_err  <= 1'b0;
        r_hold_err  <= 1'b0;
        r_hold_data <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_gnt[p]) begin
              r_state    <= ST_WAIT;
              r_pend_err <= w_err[p];
            end
          end
          ST_WAIT: begin
            if (w_rsp_ready[p]) begin
              if (w_gnt[p]) r_pend_err <= w_err[p];
              else          r_state    <= ST_IDLE;
            end else begin
              r_state     <= ST_HOLD;
              r_hold_err  <= r_pend_err;
              r_hold_data <= r_pend_err ? '0 : mem_rdata;
            end
          end
          ST_HOLD: begin
            if (w_rsp_ready[p]) r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef IMEM_ARB_ROUND_ROBIN_EN
  logic r_prio_if;   // 0: dm has priority, 1: if has priority

  // Round-robin grant: the pointer breaks ties only when both ports want.
  always_comb begin
    w_gnt = '0;
    if (w_want[c_DM] && (!w_want[c_IF] || !r_prio_if)) w_gnt[c_DM] = 1'b1;
    else if (w_want[c_IF])                              w_gnt[c_IF] = 1'b1;
  end

  // Pointer moves to the port that did not win the last grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_prio_if <= 1'b0;
    else if (w_gnt[c_DM])  r_prio_if <= 1'b1;
    else if (w_gnt[c_IF])  r_prio_if <= 1'b0;
  end
`else
  // Fixed priority grant: dm over if.
  always_comb begin
    w_gnt       = '0;
    w_gnt[c_DM] = w_want[c_DM];
    w_gnt[c_IF] = w_want[c_IF] & ~w_want[c_DM];
  end
`endif

  // Only error-free grants reach the memory; otherwise replay the last address.
  always_comb begin
    w_issue      = 1'b0;
    w_issue_addr = r_last_addr;
    if (w_gnt[c_DM] && !w_err[c_DM]) begin
      w_issue      = 1'b1;
      w_issue_addr = w_req_addr[c_DM];
    end else if (w_gnt[c_IF] && !w_err[c_IF]) begin
      w_issue      = 1'b1;
      w_issue_addr = w_req_addr[c_IF];
    end
  end

  assign mem_addr = w_issue_addr;

  // Remember the last address actually issued to memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_last_addr <= BASE_ADDR;
    else if (w_issue) r_last_addr <= w_issue_addr;
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_port_arbiter
// Purpose  : Self-checking bench for imem_port_arbiter: directed vector table,
//            hand-written hold/reset/priority sequences, and randomized
//            traffic checked against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_port_arbiter;

  localparam logic [31:0] c_BASE   = 32'h8000_0000;
  localparam int          c_MEMB   = 16392;
  localparam int          c_NWORDS = c_MEMB / 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready, if_rsp_err;
  logic [31:0] if_req_addr, if_rsp_data;
  logic        dm_req_valid, dm_req_ready, dm_rsp_valid, dm_rsp_ready, dm_rsp_err;
  logic [31:0] dm_req_addr, dm_rsp_data;
  logic [31:0] mem_addr, mem_rdata;

  imem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .BASE_ADDR(c_BASE), .MEM_BYTES(c_MEMB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_data(if_rsp_data),
    .if_rsp_err(if_rsp_err),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_req_addr(dm_req_addr),
    .dm_rsp_valid(dm_rsp_valid), .dm_rsp_ready(dm_rsp_ready), .dm_rsp_data(dm_rsp_data),
    .dm_rsp_err(dm_rsp_err),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Preloaded memory contents: word 0 is 0x13, others carry their index.
  function automatic logic [31:0] word_at(int unsigned i);
    return (i == 0) ? 32'h0000_0013 : (32'hC0DE_0000 | i);
  endfunction

  function automatic logic [31:0] mem_word(logic [31:0] a);
    if (a < c_BASE || ((a - c_BASE) >> 2) >= c_NWORDS) return 32'hDEAD_BEEF;
    return word_at((a - c_BASE) >> 2);
  endfunction

  // Synchronous-read memory, one cycle latency.
  always @(posedge clk) mem_rdata <= mem_word(mem_addr);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic string pname(int p);
    return (p == 0) ? "dm" : "if";
  endfunction

  function automatic bit addr_bad(logic [31:0] a);
    longint unsigned la;
    la = a;
    return ((a % 4) != 0) || (la < c_BASE) || (la > longint'(c_BASE) + c_MEMB - 4);
  endfunction

  // ---------------- reference model (transaction level) ----------------
  bit          m_pend [2];   // a response is owed to this port
  int          m_age  [2];   // cycles that response has already been shown
  logic [31:0] m_data [2];
  bit          m_err  [2];
  bit          m_gnt  [2];
  logic        m_rr   [2];
  logic [31:0] m_ad   [2];
  bit          m_prio_if;
  logic [31:0] m_last;

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_pend[p] = 0; m_age[p] = 0; m_gnt[p] = 0;
    end
    m_prio_if = 0;
    m_last    = c_BASE;
  endtask

  task automatic model_check();
    logic        v[2], rdy[2], rv[2], re[2];
    logic [31:0] rd[2];
    bit          want[2];
    logic [31:0] exp_ma;
    v[0] = dm_req_valid;  v[1] = if_req_valid;
    m_ad[0] = dm_req_addr; m_ad[1] = if_req_addr;
    m_rr[0] = dm_rsp_ready; m_rr[1] = if_rsp_ready;
    rdy[0] = dm_req_ready; rdy[1] = if_req_ready;
    rv[0] = dm_rsp_valid;  rv[1] = if_rsp_valid;
    rd[0] = dm_rsp_data;   rd[1] = if_rsp_data;
    re[0] = dm_rsp_err;    re[1] = if_rsp_err;
    for (int p = 0; p < 2; p++)
      want[p] = v[p] && (!m_pend[p] || (m_age[p] == 0 && m_rr[p]));
`ifdef IMEM_ARB_ROUND_ROBIN_EN
    if (want[0] && want[1]) begin
      m_gnt[0] = !m_prio_if; m_gnt[1] = m_prio_if;
    end else begin
      m_gnt[0] = want[0]; m_gnt[1] = want[1];
    end
`else
    m_gnt[0] = want[0];
    m_gnt[1] = want[1] && !want[0];
`endif
    exp_ma = m_last;
    for (int p = 0; p < 2; p++) begin
      if (m_gnt[p] && !addr_bad(m_ad[p])) exp_ma = m_ad[p];
      chk({"model ", pname(p), "_req_ready"}, rdy[p], m_gnt[p]);
      chk({"model ", pname(p), "_rsp_valid"}, rv[p], m_pend[p]);
      chk({"model ", pname(p), "_rsp_err"}, re[p], m_pend[p] ? m_err[p] : 1'b0);
      if (m_pend[p]) chk({"model ", pname(p), "_rsp_data"}, rd[p], m_data[p]);
    end
    chk("model mem_addr", mem_addr, exp_ma);
  endtask

  task automatic model_update();
    for (int p = 0; p < 2; p++) begin
      if (m_pend[p]) begin
        if (m_rr[p]) m_pend[p] = 0;
        else         m_age[p]++;
      end
      if (m_gnt[p]) begin
        m_pend[p] = 1;
        m_age[p]  = 0;
        m_err[p]  = addr_bad(m_ad[p]);
        m_data[p] = m_err[p] ? 32'h0 : word_at((m_ad[p] - c_BASE) >> 2);
        if (!m_err[p]) m_last = m_ad[p];
      end
    end
`ifdef IMEM_ARB_ROUND_ROBIN_EN
    if (m_gnt[0])      m_prio_if = 1;
    else if (m_gnt[1]) m_prio_if = 0;
`endif
  endtask

  task automatic tick_a();
    @(negedge clk);
    model_check();
  endtask

  task automatic tick_b();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic dv; logic [31:0] da; logic drr;
    logic iv; logic [31:0] ia; logic irr;
    logic e_drdy; logic e_irdy;
    logic e_drv;  logic [31:0] e_drd; logic e_dre;
    logic e_irv;  logic [31:0] e_ird; logic e_ire;
    logic [31:0] e_maddr;
  } vec_t;

  vec_t tbl [15];

  function automatic logic [31:0] rand_addr();
    int unsigned k, w;
    k = $urandom_range(0, 9);
    w = $urandom_range(0, c_NWORDS - 1);
    case (k)
      0: return c_BASE + w * 4 + $urandom_range(1, 3);
      1: return c_BASE - 4 * $urandom_range(1, 8);
      2: return c_BASE + c_MEMB + 4 * $urandom_range(0, 8);
      3: return c_BASE + c_MEMB - 4;
      default: return c_BASE + w * 4;
    endcase
  endfunction

  initial begin
    logic acc_d, acc_i;
    localparam logic [31:0] A0 = 32'h8000_0000, A4 = 32'h8000_0004, A8 = 32'h8000_0008;
    localparam logic [31:0] AC = 32'h8000_000C, A10 = 32'h8000_0010;
    //             dv da            drr iv ia            irr drdy irdy drv drd           dre irv ird           ire maddr
    tbl[0]  = '{1'b0, A0,          1'b1, 1'b0, A0,          1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, A0};
    tbl[1]  = '{1'b0, A0,          1'b1, 1'b1, A0,          1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, A0};
    tbl[2]  = '{1'b0, A0,          1'b1, 1'b0, A0,          1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h13,       1'b0, A0};
    tbl[3]  = '{1'b1, A8,          1'b1, 1'b1, A4,          1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, A8};
    tbl[4]  = '{1'b0, A8,          1'b1, 1'b1, A4,          1'b1, 1'b0, 1'b1, 1'b1, 32'hC0DE0002, 1'b0, 1'b0, 32'h0,        1'b0, A4};
    tbl[5]  = '{1'b0, A8,          1'b1, 1'b0, A4,          1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hC0DE0001, 1'b0, A4};
    tbl[6]  = '{1'b0, A8,          1'b1, 1'b1, A0,          1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, A0};
    tbl[7]  = '{1'b0, A8,          1'b1, 1'b1, A4,          1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h13,       1'b0, A4};
    tbl[8]  = '{1'b0, A8,          1'b1, 1'b1, A8,          1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'hC0DE0001, 1'b0, A8};
    tbl[9]  = '{1'b0, A8,          1'b1, 1'b0, A8,          1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hC0DE0002, 1'b0, A8};
    tbl[10] = '{1'b1, 32'h80000002,1'b1, 1'b0, A8,          1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, A8};
    tbl[11] = '{1'b1, 32'h7FFFFFFC,1'b1, 1'b0, A8,          1'b1, 1'b1, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, A8};
    tbl[12] = '{1'b1, 32'h80004008,1'b1, 1'b0, A8,          1'b1, 1'b1, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, A8};
    tbl[13] = '{1'b0, A8,          1'b1, 1'b1, 32'h80004004,1'b1, 1'b0, 1'b1, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h80004004};
    tbl[14] = '{1'b0, A8,          1'b1, 1'b0, 32'h80004004,1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hC0DE1001, 1'b0, 32'h80004004};

    if_req_valid = 0; if_req_addr = c_BASE; if_rsp_ready = 1;
    dm_req_valid = 0; dm_req_addr = c_BASE; dm_rsp_ready = 1;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset if_rsp_valid", if_rsp_valid, 0);
    chk("reset dm_rsp_valid", dm_rsp_valid, 0);
    chk("reset if_rsp_err", if_rsp_err, 0);
    chk("reset dm_rsp_err", dm_rsp_err, 0);
    chk("reset if_rsp_data", if_rsp_data, 0);
    chk("reset dm_rsp_data", dm_rsp_data, 0);
    chk("reset mem_addr", mem_addr, c_BASE);
    @(posedge clk); #1;
    rst_n = 1;

    // Directed table
    for (int i = 0; i < 15; i++) begin
      dm_req_valid = tbl[i].dv; dm_req_addr = tbl[i].da; dm_rsp_ready = tbl[i].drr;
      if_req_valid = tbl[i].iv; if_req_addr = tbl[i].ia; if_rsp_ready = tbl[i].irr;
      tick_a();
      chk($sformatf("vec%0d dm_req_ready", i), dm_req_ready, tbl[i].e_drdy);
      chk($sformatf("vec%0d if_req_ready", i), if_req_ready, tbl[i].e_irdy);
      chk($sformatf("vec%0d dm_rsp_valid", i), dm_rsp_valid, tbl[i].e_drv);
      chk($sformatf("vec%0d if_rsp_valid", i), if_rsp_valid, tbl[i].e_irv);
      chk($sformatf("vec%0d dm_rsp_err", i), dm_rsp_err, tbl[i].e_dre);
      chk($sformatf("vec%0d if_rsp_err", i), if_rsp_err, tbl[i].e_ire);
      if (tbl[i].e_drv) chk($sformatf("vec%0d dm_rsp_data", i), dm_rsp_data, tbl[i].e_drd);
      if (tbl[i].e_irv) chk($sformatf("vec%0d if_rsp_data", i), if_rsp_data, tbl[i].e_ird);
      chk($sformatf("vec%0d mem_addr", i), mem_addr, tbl[i].e_maddr);
      tick_b();
    end

    // dm response held for 3 cycles while fetch keeps streaming
    dm_req_valid = 1; dm_req_addr = AC; dm_rsp_ready = 0;
    if_req_valid = 1; if_req_addr = A0; if_rsp_ready = 1;
    tick_a(); chk("hold c0 dm_req_ready", dm_req_ready, 1); tick_b();
    dm_req_addr = A10;
    for (int c = 1; c <= 3; c++) begin
      if_req_addr = (c == 1) ? A0 : ((c == 2) ? A4 : A8);
      tick_a();
      chk($sformatf("hold c%0d dm_rsp_valid", c), dm_rsp_valid, 1);
      chk($sformatf("hold c%0d dm_rsp_data", c), dm_rsp_data, 32'hC0DE0003);
      chk($sformatf("hold c%0d dm_req_ready", c), dm_req_ready, 0);
      chk($sformatf("hold c%0d if_req_ready", c), if_req_ready, 1);
      tick_b();
    end
    if_req_valid = 0; dm_rsp_ready = 1;
    tick_a();
    chk("hold c4 dm_rsp_data", dm_rsp_data, 32'hC0DE0003);
    chk("hold c4 dm_req_ready", dm_req_ready, 0);
    chk("hold c4 if_rsp_data", if_rsp_data, 32'hC0DE0002);
    tick_b();
    tick_a(); chk("hold c5 dm_req_ready", dm_req_ready, 1); tick_b();
    dm_req_valid = 0;
    tick_a(); chk("hold c6 dm_rsp_data", dm_rsp_data, 32'hC0DE0004); tick_b();

    // Asynchronous reset while a fetch is in WAIT
    if_req_valid = 1; if_req_addr = A0; if_rsp_ready = 1;
    tick_a(); tick_b();
    if_req_valid = 0;
    chk("pre-reset if_rsp_valid", if_rsp_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("async reset if_rsp_valid", if_rsp_valid, 0);
    chk("async reset dm_rsp_valid", dm_rsp_valid, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      tick_a(); chk("post-reset if_rsp_valid", if_rsp_valid, 0); tick_b();
    end

    // Continuous dual requests from reset: priority pattern
    dm_req_valid = 1; dm_req_addr = A8; if_req_valid = 1; if_req_addr = A4;
    for (int k = 0; k < 4; k++) begin
      tick_a();
`ifdef IMEM_ARB_ROUND_ROBIN_EN
      chk($sformatf("rr%0d dm_req_ready", k), dm_req_ready, (k % 2) == 0);
      chk($sformatf("rr%0d if_req_ready", k), if_req_ready, (k % 2) == 1);
`else
      chk($sformatf("fixed%0d dm_req_ready", k), dm_req_ready, 1);
      chk($sformatf("fixed%0d if_req_ready", k), if_req_ready, 0);
`endif
      tick_b();
    end
    dm_req_valid = 0; if_req_valid = 0;
    tick_a(); tick_b();
    tick_a(); tick_b();

    // Randomized traffic against the reference model
    acc_d = 0; acc_i = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!dm_req_valid || acc_d) begin
        dm_req_valid = ($urandom_range(0, 99) < 60);
        dm_req_addr  = rand_addr();
      end
      if (!if_req_valid || acc_i) begin
        if_req_valid = ($urandom_range(0, 99) < 60);
        if_req_addr  = rand_addr();
      end
      dm_rsp_ready = ($urandom_range(0, 99) < 70);
      if_rsp_ready = ($urandom_range(0, 99) < 70);
      tick_a();
      acc_d = dm_req_valid && dm_req_ready;
      acc_i = if_req_valid && if_req_ready;
      tick_b();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
